// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - execution-unit request bus and registered CDB broadcast
interface cdb_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        rdy;
  logic                    cdb_wr;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_wdata;

  modport master (
    output req, req_tag, req_wdata,
    input  rdy, cdb_wr, cdb_tag, cdb_wdata
  );

  modport slave (
    input  req, req_tag, req_wdata,
    output rdy, cdb_wr, cdb_tag, cdb_wdata
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter: fixed priority with aging or round-robin
module cdb_arbiter #(
  parameter int N_REQ        = 3,
  parameter int TAG_W        = 4,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         prio_mode,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  cnt [N_REQ];
  logic              gnt_vld;
  logic [PTR_W-1:0]  gnt_idx;
  logic [N_REQ-1:0]  gnt;
  logic [TAG_W-1:0]  gnt_tag;
  logic [DATA_W-1:0] gnt_wdata;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Loops run from the far end downward so the last hit (the winner) overwrites earlier ones.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (rst_n && !flush) begin
      if (prio_mode) begin
        for (int k = N_REQ - 1; k >= 0; k--) begin
          if (bus.req[wrap_idx(rr_ptr, k)]) begin
            gnt_vld = 1'b1;
            gnt_idx = wrap_idx(rr_ptr, k);
          end
        end
      end else begin
        for (int i = N_REQ - 1; i >= 0; i--) begin
          if (bus.req[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = PTR_W'(i);
          end
        end
        // A starved requester overrides plain priority.
        for (int i = N_REQ - 1; i >= 0; i--) begin
          if (bus.req[i] && cnt[i] == CNT_MAX) begin
            gnt_idx = PTR_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    gnt       = '0;
    gnt_tag   = '0;
    gnt_wdata = '0;
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
      gnt_tag      = bus.req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
      gnt_wdata    = bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    end
  end

  assign bus.rdy = gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else if (!flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req[i] && !gnt[i]) begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cdb_wr    <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_wdata <= '0;
    end else begin
      bus.cdb_wr    <= gnt_vld;
      bus.cdb_tag   <= gnt_tag;
      bus.cdb_wdata <= gnt_wdata;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  localparam int N   = 3;
  localparam int TW  = 4;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic prio_mode = 1'b0;
  logic flush = 1'b0;

  cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (prio_mode),
    .flush     (flush),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [TW-1:0] utag [N];
  logic [DW-1:0] udat [N];

  int            m_cnt [N];
  int            m_ptr;
  logic          m_wr;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      bus.req_tag[i*TW +: TW]   = utag[i];
      bus.req_wdata[i*DW +: DW] = udat[i];
    end
  endtask

  task automatic new_payload(input int i);
    utag[i] = TW'($urandom);
    udat[i] = $urandom;
    pack();
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr  = 0;
    m_wr   = 1'b0;
    m_tag  = '0;
    m_data = '0;
  endtask

  function automatic int model_grant();
    if (flush || bus.req == '0) return -1;
    if (!prio_mode) begin
      for (int i = 0; i < N; i++) if (bus.req[i] && m_cnt[i] == LIM) return i;
      for (int i = 0; i < N; i++) if (bus.req[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (bus.req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle(output int g, output logic [N-1:0] seen);
    logic [N-1:0] exp_rdy;
    g = model_grant();
    exp_rdy = (g < 0) ? '0 : N'(1 << g);
    #3;
    seen = bus.rdy;
    check_eq("rdy", 64'(seen), 64'(exp_rdy));
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (flush) continue;
      if (bus.req[i] && g != i) m_cnt[i] = (m_cnt[i] < LIM) ? m_cnt[i] + 1 : LIM;
      else m_cnt[i] = 0;
    end
    if (g >= 0) begin
      m_ptr  = (g + 1) % N;
      m_wr   = 1'b1;
      m_tag  = utag[g];
      m_data = udat[g];
    end else begin
      m_wr   = 1'b0;
      m_tag  = '0;
      m_data = '0;
    end
    #1;
    check_eq("cdb_wr", 64'(bus.cdb_wr), 64'(m_wr));
    check_eq("cdb_tag", 64'(bus.cdb_tag), 64'(m_tag));
    check_eq("cdb_wdata", 64'(bus.cdb_wdata), 64'(m_data));
  endtask

  initial begin
    int g;
    logic [N-1:0] seen;

    bus.req = '0;
    for (int i = 0; i < N; i++) begin
      utag[i] = TW'(i + 1);
      udat[i] = 32'hA000_0000 + i;
    end
    pack();
    model_reset();

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) cycle(g, seen);

    // Asynchronous reset in the middle of a broadcast
    bus.req = 3'b001;
    cycle(g, seen);
    check_eq("pre_rst_wr", 64'(bus.cdb_wr), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_wr", 64'(bus.cdb_wr), 64'd0);
    check_eq("rst_tag", 64'(bus.cdb_tag), 64'd0);
    check_eq("rst_wdata", 64'(bus.cdb_wdata), 64'd0);
    check_eq("rst_rdy", 64'(bus.rdy), 64'd0);
    model_reset();
    bus.req = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) cycle(g, seen);

    // Fixed priority
    prio_mode = 1'b0;
    for (int i = 0; i < N; i++) utag[i] = TW'(i + 1);
    pack();
    bus.req = 3'b111;
    cycle(g, seen);
    check_eq("fp_rdy", 64'(seen), 64'b001);
    check_eq("fp_tag", 64'(bus.cdb_tag), 64'd1);
    bus.req = 3'b110;
    cycle(g, seen);
    check_eq("fp_drop0", 64'(seen), 64'b010);

    // Aging: unit 0 re-requests every cycle, unit 2 waits
    bus.req = '0;
    cycle(g, seen);
    bus.req = 3'b101;
    for (int c = 0; c < 6; c++) begin
      cycle(g, seen);
      check_eq("age_rdy", 64'(seen), (c == 4) ? 64'b100 : 64'b001);
      if (g == 0) new_payload(0);
    end
    bus.req = '0;
    cycle(g, seen);

    // Round-robin: steer pointer to 0 by granting unit 2 first
    prio_mode = 1'b1;
    bus.req = 3'b100;
    cycle(g, seen);
    bus.req = 3'b111;
    for (int c = 0; c < 5; c++) begin
      cycle(g, seen);
      check_eq("rr_seq", 64'(g), 64'(c % 3));
      check_eq("rr_wr", 64'(bus.cdb_wr), 64'd1);
      new_payload(g);
    end

    // Pointer now 2: sparse request wraps to 0, then search from 1 finds 2
    bus.req = 3'b001;
    cycle(g, seen);
    check_eq("rr_wrap0", 64'(seen), 64'b001);
    bus.req = 3'b101;
    cycle(g, seen);
    check_eq("rr_wrap2", 64'(seen), 64'b100);

    // Flush holds starve counters: unit 2 ages 3, flush, ages 1 more, then wins
    prio_mode = 1'b0;
    bus.req = '0;
    cycle(g, seen);
    bus.req = 3'b101;
    repeat (3) cycle(g, seen);
    flush = 1'b1;
    cycle(g, seen);
    check_eq("flush_rdy", 64'(seen), 64'd0);
    check_eq("flush_wr", 64'(bus.cdb_wr), 64'd0);
    flush = 1'b0;
    cycle(g, seen);
    check_eq("post_flush0", 64'(seen), 64'b001);
    cycle(g, seen);
    check_eq("post_flush2", 64'(seen), 64'b100);
    bus.req = '0;
    cycle(g, seen);

    // Randomized traffic with mode changes and flushes
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(15) == 0) prio_mode = ~prio_mode;
      flush = ($urandom_range(7) == 0);
      cycle(g, seen);
      if (g >= 0) begin
        bus.req[g] = $urandom_range(1);
        new_payload(g);
      end
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && i != g && $urandom_range(1) == 1) begin
          bus.req[i] = 1'b1;
          new_payload(i);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
